cnn_dma_ctrl: RTL
=================

// Module: cnn_dma_ctrl
// PURPOSE
//  Upstream feeder for the CNN accelerator ICB slave. It streams weight words, then input words, from system
//  memory into the accelerator FIFOs and polls FINISH_STATUS. It then drains the result words back to memory.
//  Sits between a memory port (ICB-style master) and the accelerator ICB slave; started by the CPU via start/cfg_*.
// PARAMETERS
//  ACC_BASE      32'h1004_2000  accelerator base; offsets IN=0x00 W=0x04 OUT=0x08 FIN=0x10 added (addr[7:0])
//  LEN_W         16             width of word-count config fields
//  POLL_GAP      8              idle cycles between successive FINISH_STATUS reads (>=1)
//  POLL_TIMEOUT  4096           max FINISH_STATUS reads before giving up with err
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous active-high reset
//  start            in   1      1-cycle pulse; latches cfg_*; ignored while busy
//  cfg_w_base       in   32     memory byte address of weights (word aligned)
//  cfg_w_len        in   LEN_W  weight word count (0 = skip phase)
//  cfg_i_base       in   32     memory byte address of input feature words
//  cfg_i_len        in   LEN_W  input word count (0 = skip)
//  cfg_o_base       in   32     memory byte address for results
//  cfg_o_len        in   LEN_W  result word count (0 = skip poll and drain)
//  busy             out  1      high from accepted start until done/err
//  done             out  1      1-cycle pulse on successful completion
//  err              out  1      1-cycle pulse on poll timeout
//  mem_cmd_valid/ready  out/in 1   memory command handshake
//  mem_cmd_addr     out  32     memory byte address
//  mem_cmd_read     out  1      1=read 0=write
//  mem_cmd_wdata    out  32     memory write data
//  mem_rsp_valid    in   1      memory response valid
//  mem_rsp_ready    out  1      constant 1
//  mem_rsp_rdata    in   32     memory read data
//  acc_cmd_valid/ready  out/in 1   accelerator ICB command handshake
//  acc_cmd_addr     out  32     ACC_BASE + offset
//  acc_cmd_read     out  1      1=read 0=write
//  acc_cmd_wdata    out  32     word pushed to IN/W FIFO
//  acc_rsp_valid    in   1      accelerator response valid (may coincide with the write cmd handshake)
//  acc_rsp_ready    out  1      constant 1
//  acc_rsp_rdata    in   32     accelerator read data
// BEHAVIOUR
//  Reset: state IDLE; busy/done/err/all cmd_valid=0; addr/wdata/counters=0; rsp_ready=1 always.
//  FSM: IDLE -> W_MRD -> W_AWR -> (loop cfg_w_len) -> I_MRD -> I_AWR -> (loop cfg_i_len) -> POLL_GAP -> POLL_RD
//       -> (FIN==32'h10 ? O_ARD : POLL_GAP) -> O_MWR -> (loop cfg_o_len) -> DONE -> IDLE.
//  *_MRD: read mem; *_AWR: write word to acc W(0x04)/IN(0x00); O_ARD: read acc 0x08; O_MWR: write word to mem.
//  One outstanding transaction per port. Issue a cmd only after the previous rsp. Data moves via a 32-bit holding reg.
//  Cmd rules: valid is held with addr/read/wdata stable until ready; the handshake is the cycle valid&ready.
//  Rsp rules: acc write rsp may arrive in the handshake cycle or later; read rsp arrives >=1 cycle after.
//    Rsp valid when no transaction is outstanding is dropped silently.
//  Per-word latency: a state advances the cycle after its rsp. Zero-wait slaves give <=4 cycles/word.
//  Addresses: base + 4*index, 32-bit wrap-around, no error. Counters are LEN_W bits; phase ends when index==len.
//  Zero-length phase skipped in 0 cycles of that phase. cfg_o_len==0 -> W/I phases then DONE (no poll).
//  Poll: count reads; the read number POLL_TIMEOUT without FIN==0x10 -> err pulse, busy=0, IDLE (no drain).
//  done/err assert the cycle after the final rsp; busy falls in the same cycle.
//  start during busy ignored. start coinciding with rst: rst wins.
//  rst mid-operation returns to IDLE next edge and deasserts cmd_valid (ICB protocol violation accepted on reset).
//  Late rsps after reset are dropped.
//  Ordering is guaranteed: all weights before any input (matches acc weight-priority FIFO arbitration).
// STRUCTURE
//  cnn_dma_pkg: state enum localparams, acc offsets (IN/W/OUT/FIN), FIN_VALUE=32'h10, word stride 4.
//  One sub-module, cnn_icb_xact: single-outstanding ICB master slot (valid hold, pending flag, rsp capture).
//    Instantiated twice (mem, acc). Top holds FSM, counters, address gens, holding reg, poll counters.
// TESTING
//  w_len=2,i_len=3,o_len=1, zero-wait slaves -> acc writes 0x04,0x04,0x00,0x00,0x00 in order; done once; busy low.
//  acc_cmd_ready low 5 cycles mid-I phase -> addr/wdata stable throughout; no word lost or duplicated.
//  FIN returns 0x0 for 3 polls then 0x10 -> exactly 4 reads at 0x10, >=POLL_GAP idle cycles apart; then drain.
//  POLL_TIMEOUT=4 with FIN never set -> 4 poll reads; err pulse; no O_ARD issued; done never asserts.
//  cfg_w_base=32'hFFFF_FFFC, w_len=2 -> mem reads at 0xFFFF_FFFC then 0x0000_0000.
//  rst pulsed during O_MWR; then start again -> clean restart; stale mem rsp ignored; output matches golden.

Source files
------------

// File: rtl/cnn_dma_pkg.sv
// Shared types and constants for the CNN accelerator DMA feeder.
package cnn_dma_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_W_MRD, S_W_AWR, S_I_MRD, S_I_AWR,
    S_POLL_GAP, S_POLL_RD, S_O_ARD, S_O_MWR, S_DONE
  } state_e;

  localparam logic [7:0]  OFF_IN      = 8'h00;
  localparam logic [7:0]  OFF_W       = 8'h04;
  localparam logic [7:0]  OFF_OUT     = 8'h08;
  localparam logic [7:0]  OFF_FIN     = 8'h10;
  localparam logic [31:0] FIN_VALUE   = 32'h10;
  localparam int          WORD_STRIDE = 4;

  // First non-empty phase in W -> I -> poll order; DONE when nothing is left.
  function automatic state_e entry_state(logic w_nz, logic i_nz, logic o_nz);
    if (w_nz) return S_W_MRD;
    if (i_nz) return S_I_MRD;
    if (o_nz) return S_POLL_GAP;
    return S_DONE;
  endfunction

endpackage

// File: rtl/cnn_icb_xact.sv
// Single-outstanding ICB master slot: holds a command until accepted, then
// waits for its response. Responses with nothing outstanding are dropped.
module cnn_icb_xact (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        read_i,
  input  logic [31:0] wdata_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [31:0] cmd_addr_o,
  output logic        cmd_read_o,
  output logic [31:0] cmd_wdata_o,
  input  logic        rsp_valid_i,
  output logic        rsp_fire_o
);

  logic        valid_q, pend_q, read_q;
  logic [31:0] addr_q, wdata_q;
  logic        hs;

  assign hs          = valid_q & cmd_ready_i;
  // A write response may land in the same cycle as its handshake.
  assign rsp_fire_o  = rsp_valid_i & (pend_q | hs);
  assign cmd_valid_o = valid_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_read_o  = read_q;
  assign cmd_wdata_o = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (req_i) begin
        valid_q <= 1'b1;
        addr_q  <= addr_i;
        read_q  <= read_i;
        wdata_q <= wdata_i;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
      if (hs && !rsp_fire_o) pend_q <= 1'b1;
      else if (rsp_fire_o)   pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cnn_dma_ctrl.sv
// DMA feeder: streams weights then inputs into the accelerator, polls
// FINISH_STATUS, then drains result words back to system memory.
module cnn_dma_ctrl import cnn_dma_pkg::*; #(
  parameter logic [31:0] ACC_BASE     = 32'h1004_2000,
  parameter int          LEN_W        = 16,
  parameter int          POLL_GAP     = 8,
  parameter int          POLL_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cfg_w_base,
  input  logic [LEN_W-1:0] cfg_w_len,
  input  logic [31:0]      cfg_i_base,
  input  logic [LEN_W-1:0] cfg_i_len,
  input  logic [31:0]      cfg_o_base,
  input  logic [LEN_W-1:0] cfg_o_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_cmd_valid,
  input  logic             mem_cmd_ready,
  output logic [31:0]      mem_cmd_addr,
  output logic             mem_cmd_read,
  output logic [31:0]      mem_cmd_wdata,
  input  logic             mem_rsp_valid,
  output logic             mem_rsp_ready,
  input  logic [31:0]      mem_rsp_rdata,
  output logic             acc_cmd_valid,
  input  logic             acc_cmd_ready,
  output logic [31:0]      acc_cmd_addr,
  output logic             acc_cmd_read,
  output logic [31:0]      acc_cmd_wdata,
  input  logic             acc_rsp_valid,
  output logic             acc_rsp_ready,
  input  logic [31:0]      acc_rsp_rdata
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d, wlen_q, wlen_d, ilen_q, ilen_d, olen_q, olen_d;
  logic [31:0]      wbase_q, wbase_d, ibase_q, ibase_d, obase_q, obase_d;
  logic [31:0]      hold_q, hold_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [PW-1:0]    poll_q, poll_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic             mem_req, mem_read, acc_req, acc_read, mem_fire, acc_fire;
  logic [31:0]      mem_addr, acc_addr;

  function automatic logic [31:0] waddr(logic [31:0] b, logic [LEN_W-1:0] i);
    return b + 32'(i) * 32'(WORD_STRIDE);
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    poll_d  = poll_q;
    hold_d  = hold_q;
    wbase_d = wbase_q; ibase_d = ibase_q; obase_d = obase_q;
    wlen_d  = wlen_q;  ilen_d  = ilen_q;  olen_d  = olen_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        wbase_d = cfg_w_base; ibase_d = cfg_i_base; obase_d = cfg_o_base;
        wlen_d  = cfg_w_len;  ilen_d  = cfg_i_len;  olen_d  = cfg_o_len;
        idx_d   = '0;
        gap_d   = '0;
        poll_d  = '0;
        state_d = entry_state(cfg_w_len != 0, cfg_i_len != 0, cfg_o_len != 0);
      end
      S_W_MRD, S_I_MRD: if (mem_fire) begin
        hold_d  = mem_rsp_rdata;
        state_d = (state_q == S_W_MRD) ? S_W_AWR : S_I_AWR;
      end
      S_W_AWR: if (acc_fire) begin
        idx_d = idx_q + 1'b1;
        if (idx_d == wlen_q) begin
          idx_d   = '0;
          state_d = entry_state(1'b0, ilen_q != 0, olen_q != 0);
        end else state_d = S_W_MRD;
      end
      S_I_AWR: if (acc_fire) begin
        idx_d = idx_q + 1'b1;
        if (idx_d == ilen_q) begin
          idx_d   = '0;
          state_d = entry_state(1'b0, 1'b0, olen_q != 0);
        end else state_d = S_I_MRD;
      end
      S_POLL_GAP: if (gap_q == GW'(POLL_GAP - 1)) begin
        gap_d   = '0;
        state_d = S_POLL_RD;
      end else gap_d = gap_q + 1'b1;
      S_POLL_RD: if (acc_fire) begin
        poll_d = poll_q + 1'b1;
        if (acc_rsp_rdata == FIN_VALUE) state_d = S_O_ARD;
        else if (poll_d == PW'(POLL_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else state_d = S_POLL_GAP;
      end
      S_O_ARD: if (acc_fire) begin
        hold_d  = acc_rsp_rdata;
        state_d = S_O_MWR;
      end
      S_O_MWR: if (mem_fire) begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == olen_q) ? S_DONE : S_O_ARD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Every command-issuing state launches exactly one command on entry.
    mem_req  = 1'b0; mem_read = 1'b1; mem_addr = '0;
    acc_req  = 1'b0; acc_read = 1'b0; acc_addr = '0;
    if (state_d != state_q) begin
      case (state_d)
        S_W_MRD:   begin mem_req = 1'b1; mem_addr = waddr(wbase_d, idx_d); end
        S_I_MRD:   begin mem_req = 1'b1; mem_addr = waddr(ibase_d, idx_d); end
        S_O_MWR:   begin mem_req = 1'b1; mem_read = 1'b0; mem_addr = waddr(obase_d, idx_d); end
        S_W_AWR:   begin acc_req = 1'b1; acc_addr = ACC_BASE + {24'h0, OFF_W}; end
        S_I_AWR:   begin acc_req = 1'b1; acc_addr = ACC_BASE + {24'h0, OFF_IN}; end
        S_POLL_RD: begin acc_req = 1'b1; acc_read = 1'b1; acc_addr = ACC_BASE + {24'h0, OFF_FIN}; end
        S_O_ARD:   begin acc_req = 1'b1; acc_read = 1'b1; acc_addr = ACC_BASE + {24'h0, OFF_OUT}; end
        default: ;
      endcase
    end

    busy_d = !(state_d inside {S_IDLE, S_DONE});
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0; gap_q <= '0; poll_q <= '0; hold_q <= '0;
      wbase_q <= '0; ibase_q <= '0; obase_q <= '0;
      wlen_q  <= '0; ilen_q  <= '0; olen_q  <= '0;
      busy_q  <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d; gap_q <= gap_d; poll_q <= poll_d; hold_q <= hold_d;
      wbase_q <= wbase_d; ibase_q <= ibase_d; obase_q <= obase_d;
      wlen_q  <= wlen_d;  ilen_q  <= ilen_d;  olen_q  <= olen_d;
      busy_q  <= busy_d; done_q <= done_d; err_q <= err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign mem_rsp_ready = 1'b1;
  assign acc_rsp_ready = 1'b1;

  cnn_icb_xact u_mem (
    .clk(clk), .rst(rst), .req_i(mem_req), .addr_i(mem_addr), .read_i(mem_read),
    .wdata_i(hold_d), .cmd_valid_o(mem_cmd_valid), .cmd_ready_i(mem_cmd_ready),
    .cmd_addr_o(mem_cmd_addr), .cmd_read_o(mem_cmd_read), .cmd_wdata_o(mem_cmd_wdata),
    .rsp_valid_i(mem_rsp_valid), .rsp_fire_o(mem_fire)
  );

  cnn_icb_xact u_acc (
    .clk(clk), .rst(rst), .req_i(acc_req), .addr_i(acc_addr), .read_i(acc_read),
    .wdata_i(hold_d), .cmd_valid_o(acc_cmd_valid), .cmd_ready_i(acc_cmd_ready),
    .cmd_addr_o(acc_cmd_addr), .cmd_read_o(acc_cmd_read), .cmd_wdata_o(acc_cmd_wdata),
    .rsp_valid_i(acc_rsp_valid), .rsp_fire_o(acc_fire)
  );

endmodule
